// File: rtl/dram_timing_pkg.sv
// Timing defaults and state encoding shared by the refresh scheduler and the
// downstream refresh command state machine.
package dram_timing_pkg;

    localparam int unsigned T_REFI_DEFAULT = 780;
    localparam int unsigned T_RFC_DEFAULT  = 103;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        LOCKOUT = 2'b10
    } refresh_state_e;

    // Bits needed to hold a counter whose largest value is max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/refi_timer.sv
// Free-running tREFI interval counter: counts 0..T_REFI-1, wraps, and asserts
// tick_o for the single cycle in which the count equals T_REFI-1.
module refi_timer
    import dram_timing_pkg::*;
#(
    parameter int unsigned T_REFI = T_REFI_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned W    = cnt_width(T_REFI - 1);
    localparam logic [W-1:0] LAST = W'(T_REFI - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/refresh_scheduler.sv
// Periodic refresh scheduler: owes one refresh per tREFI tick, issues it when the
// command path is idle, then locks out for tRFC+GUARD. Optional pull-in of
// refreshes ahead of schedule is enabled by defining REFRESH_PULLIN_EN.
module refresh_scheduler
    import dram_timing_pkg::*;
#(
    parameter int unsigned T_REFI       = T_REFI_DEFAULT,
    parameter int unsigned T_RFC        = T_RFC_DEFAULT,
    parameter int unsigned GUARD        = 2,
`ifdef REFRESH_PULLIN_EN
    parameter int unsigned MAX_PULLIN   = 8,
`endif
    // Must not exceed 15 so that the owed count fits pending_cnt.
    parameter int unsigned MAX_POSTPONE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_idle,
    output logic       refresh_signal,
    output logic       refresh_busy,
    output logic       refresh_urgent,
    output logic [3:0] pending_cnt,
    output logic       overflow,
    output logic [1:0] state_dbg
);

    localparam int unsigned PW = cnt_width(MAX_POSTPONE);
    localparam int unsigned LW = cnt_width(T_RFC + GUARD);
    localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_POSTPONE);
    localparam logic [PW-1:0] URGENT_LVL = PW'(MAX_POSTPONE - 1);
    localparam logic [LW-1:0] LOCK_LOAD  = LW'(T_RFC + GUARD - 1);

    refresh_state_e state_q;
    logic [PW-1:0]  pending_q, pending_d;
    logic [LW-1:0]  lock_q;
    logic           overflow_q, overflow_d;
    logic           signal_q;
    logic           tick;
    logic           in_issue, issue_go, tick_pend, dec_pend;

`ifdef REFRESH_PULLIN_EN
    localparam int unsigned QW = cnt_width(MAX_PULLIN);
    localparam logic [QW-1:0] PULLIN_MAX = QW'(MAX_PULLIN);

    logic [QW-1:0] pullin_q, pullin_d;
    logic          owed_q;
    logic          owed_go, pull_go;
`endif

    refi_timer #(
        .T_REFI(T_REFI)
    ) u_refi_timer (
        .clk_i (clk),
        .rst_i (rst),
        .tick_o(tick)
    );

    // Contract with the arbiter: cmd_idle is sampled only in IDLE; once a pulse
    // is issued, refresh_busy stays high until the full lockout has elapsed.
    always_comb begin
        in_issue = (state_q == ISSUE);
`ifdef REFRESH_PULLIN_EN
        owed_go  = (state_q == IDLE) && cmd_idle && (pending_q != '0);
        pull_go  = (state_q == IDLE) && cmd_idle && (pending_q == '0) && (pullin_q < PULLIN_MAX);
        issue_go = owed_go || pull_go;
        // A tick in the cycle a pull-in is granted is absorbed by that pull-in.
        tick_pend = tick && (pullin_q == '0) && !pull_go;
        dec_pend  = in_issue && owed_q;
        pullin_d  = pullin_q;
        if (pull_go && !tick) begin
            pullin_d = pullin_q + QW'(1);
        end else if (!pull_go && tick && (pullin_q != '0)) begin
            pullin_d = pullin_q - QW'(1);
        end
`else
        issue_go  = (state_q == IDLE) && cmd_idle && (pending_q != '0);
        tick_pend = tick;
        dec_pend  = in_issue;
`endif
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (tick_pend && (pending_q == PEND_MAX)) begin
            overflow_d = 1'b1;
        end
        if (tick_pend && !dec_pend) begin
            if (pending_q != PEND_MAX) begin
                pending_d = pending_q + PW'(1);
            end
        end else if (!tick_pend && dec_pend) begin
            pending_d = pending_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            lock_q     <= '0;
            overflow_q <= 1'b0;
            signal_q   <= 1'b0;
`ifdef REFRESH_PULLIN_EN
            pullin_q   <= '0;
            owed_q     <= 1'b0;
`endif
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
`ifdef REFRESH_PULLIN_EN
            pullin_q   <= pullin_d;
`endif
            case (state_q)
                IDLE: begin
                    if (issue_go) begin
                        state_q  <= ISSUE;
                        signal_q <= 1'b1;
`ifdef REFRESH_PULLIN_EN
                        owed_q   <= owed_go;
`endif
                    end
                end
                ISSUE: begin
                    state_q  <= LOCKOUT;
                    signal_q <= 1'b0;
                    lock_q   <= LOCK_LOAD;
                end
                LOCKOUT: begin
                    if (lock_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        lock_q <= lock_q - LW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    signal_q <= 1'b0;
                end
            endcase
        end
    end

    assign refresh_signal = signal_q;
    assign refresh_busy   = (state_q != IDLE);
    assign refresh_urgent = (pending_q >= URGENT_LVL);
    assign pending_cnt    = 4'(pending_q);
    assign overflow       = overflow_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: directed vector table, randomized idle traffic
// against a time-based reference model, and long-interval pulse sequences.
module tb_refresh_scheduler;

    localparam int TB_REFI = 20;
    localparam int TB_LOCK = 103 + 2;
    localparam int TB_MAXP = 8;
    localparam int L_REFI  = 1000;
    localparam int L_SPACE = 107;

    typedef struct {
        bit   rst;
        int   n;
        bit   idle;
        bit   sig;
        bit   busy;
        int   pend;
        bit   urg;
        bit   ovf;
        int   st;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, cmd_idle = 1'b0;
    logic       sig, busy, urg, ovf;
    logic [3:0] pend;
    logic [1:0] st;

    logic       rst_l = 1'b1, idle_l = 1'b0;
    logic       sig_l, busy_l, urg_l, ovf_l;
    logic [3:0] pend_l;
    logic [1:0] st_l;

    refresh_scheduler #(.T_REFI(TB_REFI)) dut (
        .clk(clk), .rst(rst), .cmd_idle(cmd_idle),
        .refresh_signal(sig), .refresh_busy(busy), .refresh_urgent(urg),
        .pending_cnt(pend), .overflow(ovf), .state_dbg(st)
    );

    refresh_scheduler #(.T_REFI(L_REFI)) dut_l (
        .clk(clk), .rst(rst_l), .cmd_idle(idle_l),
        .refresh_signal(sig_l), .refresh_busy(busy_l), .refresh_urgent(urg_l),
        .pending_cnt(pend_l), .overflow(ovf_l), .state_dbg(st_l)
    );

    // ---------------- scoreboard / model ----------------
    int errors = 0;
    int checks = 0;
    int seg = 0;
    int m_cyc, m_pend, m_ovf, m_last;
    int exp_q[$];
    int got_q[$];
    vec_t tbl[27];
    vec_t vnone;

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_pend = 0;
        m_ovf  = 0;
        m_last = -100000;
    endtask

    // Pulse/busy derived from time since the last pulse; owed count from ticks.
    task automatic model_check();
        int e_sig, e_busy, e_st;
        e_sig  = (m_cyc == m_last) ? 1 : 0;
        e_busy = (m_cyc - m_last <= TB_LOCK) ? 1 : 0;
        e_st   = e_sig ? 1 : (e_busy ? 2 : 0);
        chk("model_signal", m_cyc, int'(sig), e_sig);
        chk("model_busy", m_cyc, int'(busy), e_busy);
        chk("model_pending", m_cyc, int'(pend), m_pend);
        chk("model_urgent", m_cyc, int'(urg), (m_pend >= TB_MAXP - 1) ? 1 : 0);
        chk("model_overflow", m_cyc, int'(ovf), m_ovf);
        chk("model_state", m_cyc, int'(st), e_st);
    endtask

    task automatic model_update(input bit idle);
        bit tick, sig_now, busy_now;
        int p0;
        tick     = (m_cyc % TB_REFI) == TB_REFI - 1;
        sig_now  = (m_cyc == m_last);
        busy_now = (m_cyc - m_last <= TB_LOCK);
        p0       = m_pend;
        if (tick && m_pend == TB_MAXP) m_ovf = 1;
        if (tick && !sig_now) begin
            if (m_pend < TB_MAXP) m_pend++;
        end else if (!tick && sig_now) begin
            m_pend--;
        end
        if (!busy_now && p0 > 0 && idle) m_last = m_cyc + 1;
        m_cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst      = 1'b1;
        cmd_idle = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_cycle(input bit idle, input bit tchk, input vec_t v);
        cmd_idle = idle;
        @(negedge clk);
        model_check();
        if (tchk) begin
            chk($sformatf("tbl%0d_signal", seg), m_cyc, int'(sig), int'(v.sig));
            chk($sformatf("tbl%0d_busy", seg), m_cyc, int'(busy), int'(v.busy));
            chk($sformatf("tbl%0d_pending", seg), m_cyc, int'(pend), v.pend);
            chk($sformatf("tbl%0d_urgent", seg), m_cyc, int'(urg), int'(v.urg));
            chk($sformatf("tbl%0d_overflow", seg), m_cyc, int'(ovf), int'(v.ovf));
            chk($sformatf("tbl%0d_state", seg), m_cyc, int'(st), v.st);
        end
        model_update(idle);
        @(posedge clk);
        #1;
    endtask

    task automatic long_reset();
        rst_l  = 1'b1;
        idle_l = 1'b0;
        @(posedge clk);
        #1;
        rst_l = 1'b0;
    endtask

    task automatic compare_pulses(input string name);
        chk({name, "_count"}, 0, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk({name, "_cycle"}, 0, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int pcts[4];
        vnone = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        pcts  = '{5, 60, 95, 100};
        // {rst, cycles, idle, sig, busy, pend, urg, ovf, state} checked on the last cycle
        tbl[0]  = '{1,  19, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0,   1, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0,   1, 1, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0,   1, 1, 1, 1, 1, 0, 0, 1};
        tbl[4]  = '{0,   1, 1, 0, 1, 0, 0, 0, 2};
        tbl[5]  = '{0, 104, 1, 0, 1, 5, 0, 0, 2};
        tbl[6]  = '{0,   1, 1, 0, 0, 5, 0, 0, 0};
        tbl[7]  = '{0,   1, 1, 1, 1, 5, 0, 0, 1};
        tbl[8]  = '{0,   1, 1, 0, 1, 4, 0, 0, 2};
        tbl[9]  = '{1, 140, 0, 0, 0, 6, 0, 0, 0};
        tbl[10] = '{0,   1, 0, 0, 0, 7, 1, 0, 0};
        tbl[11] = '{0,  39, 0, 0, 0, 8, 1, 0, 0};
        tbl[12] = '{0,   1, 0, 0, 0, 8, 1, 1, 0};
        tbl[13] = '{0,  40, 0, 0, 0, 8, 1, 1, 0};
        tbl[14] = '{0,   1, 1, 0, 0, 8, 1, 1, 0};
        tbl[15] = '{0,   1, 1, 1, 1, 8, 1, 1, 1};
        tbl[16] = '{0,   1, 1, 0, 1, 7, 1, 1, 2};
        tbl[17] = '{1,  38, 0, 0, 0, 1, 0, 0, 0};
        tbl[18] = '{0,   1, 1, 0, 0, 1, 0, 0, 0};
        tbl[19] = '{0,   1, 1, 1, 1, 1, 0, 0, 1};
        tbl[20] = '{0,   1, 1, 0, 1, 1, 0, 0, 2};
        tbl[21] = '{0,  49, 0, 0, 1, 3, 0, 0, 2};
        tbl[22] = '{1,   1, 1, 0, 0, 0, 0, 0, 0};
        tbl[23] = '{0,  20, 1, 0, 0, 1, 0, 0, 0};
        tbl[24] = '{0,   1, 1, 1, 1, 1, 0, 0, 1};
        tbl[25] = '{0,   1, 1, 0, 1, 0, 0, 0, 2};
        tbl[26] = '{0,  30, 1, 0, 1, 1, 0, 0, 2};

        model_reset();
        #1;

`ifndef REFRESH_PULLIN_EN
        for (int i = 0; i < 27; i++) begin
            seg = i;
            if (tbl[i].rst) do_reset();
            for (int j = 0; j < tbl[i].n; j++) begin
                run_cycle(tbl[i].idle, j == tbl[i].n - 1, tbl[i]);
            end
        end

        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 700; j++) begin
                if ($urandom_range(0, 499) == 0) do_reset();
                run_cycle($urandom_range(0, 99) < pcts[b], 1'b0, vnone);
            end
        end
`endif

        // Three owed refreshes drained back to back at minimum spacing.
        long_reset();
        for (int c = 0; c < 3300; c++) begin
            idle_l = (c >= 3000);
            @(negedge clk);
            if (sig_l && c < 3300) got_q.push_back(c);
            if (c == 3000) begin
                chk("long_pend_3000", c, int'(pend_l), 3);
                chk("long_busy_3000", c, int'(busy_l), 0);
                chk("long_urgent_3000", c, int'(urg_l), 0);
                chk("long_ovf_3000", c, int'(ovf_l), 0);
                chk("long_state_3000", c, int'(st_l), 0);
            end
            if (c == 3002) chk("long_pend_3002", c, int'(pend_l), 2);
            if (c == 3109) chk("long_pend_3109", c, int'(pend_l), 1);
            if (c == 3216) chk("long_pend_3216", c, int'(pend_l), 0);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(3001 + L_SPACE * k);
        while (got_q.size() > 3) void'(got_q.pop_back());
        compare_pulses("long_drain");

`ifdef REFRESH_PULLIN_EN
        // Eight pull-ins before the first tick, then one refill after it.
        long_reset();
        for (int c = 0; c < 1100; c++) begin
            idle_l = 1'b1;
            @(negedge clk);
            if (sig_l) got_q.push_back(c);
            if (c == 998 || c == 1000) chk("pullin_pend", c, int'(pend_l), 0);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(1 + L_SPACE * k);
        exp_q.push_back(1001);
        compare_pulses("pullin");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/refresh_scheduler.md
# refresh_scheduler

Periodic refresh scheduler sitting directly upstream of the DRAM refresh command state machine. It counts the tREFI interval, tracks owed refreshes with a bounded postponement budget, and issues a single-cycle `refresh_signal` pulse only when the main command path reports idle. It then holds off further refresh issue until the downstream tRFC window plus a guard has elapsed. It also tells the command arbiter when refresh has become urgent, so the arbiter can drain traffic first.

## Interface
- `T_REFI`, 780 — refresh interval in clk cycles (7.8 us at 100 MHz).
- `T_RFC`, 103 — refresh cycle time; must equal the downstream state machine's tRFC.
- `GUARD`, 2 — extra lockout cycles after tRFC.
- `MAX_POSTPONE`, 8 — maximum owed refreshes.
- `MAX_PULLIN`, 8 — maximum refreshes issued ahead of schedule (used only with the macro).

Ports:
- `clk`  in  1  — single clock; all logic on posedge.
- `rst`  in  1  — synchronous, active-high reset.
- `cmd_idle`  in  1  — no read/write/activate is in flight or being issued this cycle.
- `refresh_signal`  out  1  — one-cycle refresh request pulse to the refresh state machine.
- `refresh_busy`  out  1  — high during ISSUE and LOCKOUT; the arbiter must not issue commands.
- `refresh_urgent`  out  1  — `pending >= MAX_POSTPONE-1`; the arbiter must stop new traffic.
- `pending_cnt`  out  4  — current owed-refresh count.
- `overflow`  out  1  — sticky error flag; set when a tick arrives while `pending == MAX_POSTPONE`.

## Operation
- **Interval counter**
  - Counts 0..T_REFI-1 and wraps.
  - `tick` is asserted in the cycle where the count equals T_REFI-1.
  - It runs freely, independent of state.
- **Pending counter** (0..MAX_POSTPONE)
  - Increments on `tick` and decrements in the ISSUE cycle.
  - If both occur in the same cycle, it is unchanged.
  - Saturates at MAX_POSTPONE. A tick while saturated sets `overflow` and leaves `pending` unchanged.
- **State machine**
  - IDLE → ISSUE when `pending > 0 && cmd_idle`.
  - ISSUE → LOCKOUT, always after 1 cycle.
  - LOCKOUT → IDLE after exactly T_RFC+GUARD cycles, timed by a lockout counter loaded on entry.
  - Issue in IDLE always requires `cmd_idle`; urgency never bypasses it. The arbiter is responsible for reaching idle.
- **Outputs**
  - `refresh_signal` is registered and equals (state == ISSUE).
  - `refresh_busy` = (state != IDLE).
  - `refresh_urgent` is combinational from `pending`.
- **Reset** (any state, including mid-LOCKOUT)
  - State goes to IDLE; interval, lockout and pending counters clear to 0; `overflow` clears to 0.
  - All outputs are 0 in the first cycle after reset.
  - A refresh interrupted by reset is not re-owed.
- **Width rules**
  - Counter widths are `$clog2` of their maximum plus 1.
  - `pending_cnt` is zero-extended to 4 bits.
  - Parameters are legal only if `MAX_POSTPONE <= 15`.

## Timing
- Tick in cycle k (counted from the first cycle after `rst` deasserts, k = 0):
  - `pending` = 1 in k+1.
  - `refresh_signal` = 1 in k+2, provided `cmd_idle` = 1 in k+1.
- Pulse width is exactly 1 cycle.
- Minimum spacing between pulses is T_RFC+GUARD+2 cycles (107 with defaults).
- `refresh_busy` rises in the pulse cycle and falls T_RFC+GUARD+1 cycles later.
- `cmd_idle` is sampled only in IDLE. Its value during ISSUE/LOCKOUT is ignored.

## Configuration
- `REFRESH_PULLIN_EN` defined:
  - Adds a pull-in counter (0..MAX_PULLIN).
  - In IDLE with `pending == 0`, `cmd_idle`, and `pullin < MAX_PULLIN`, the block issues a refresh and increments `pullin`.
  - A tick while `pullin > 0` decrements `pullin` instead of incrementing `pending`.
  - Reset clears `pullin`.
- Not defined: there is no pull-in logic, and refreshes issue only when `pending > 0`.

## Structure
- Shared package `dram_timing_pkg`:
  - T_REFI and T_RFC defaults, shared with the refresh state machine.
  - State encoding constants: IDLE = 2'b00, ISSUE = 2'b01, LOCKOUT = 2'b10.
- Sub-module `refi_timer`:
  - Wrapping interval counter with a `tick` output and synchronous reset.
  - Everything else lives in the top module.

## Test plan
- T_REFI = 20, `cmd_idle` held 1 after reset → tick at cycle 19, `refresh_signal` pulse at cycle 21 for 1 cycle; `refresh_busy` high cycles 21..126 with defaults.
- `cmd_idle` = 0 through 9 ticks (T_REFI = 20):
  - `pending_cnt` climbs to 8.
  - `refresh_urgent` rises at `pending` = 7.
  - `overflow` sets on the 9th tick; `pending` stays 8.
  - No pulses are issued.
- `pending` = 3, then `cmd_idle` = 1 → three pulses spaced exactly 107 cycles apart; `pending_cnt` 3→2→1→0.
- Tick coincides with the ISSUE cycle → `pending_cnt` is unchanged across that edge.
- `rst` asserted 50 cycles into LOCKOUT → next cycle: state IDLE, all outputs 0, `pending_cnt` 0, `overflow` 0, interval restarts from 0.
- `REFRESH_PULLIN_EN`, T_REFI = 1000, `cmd_idle` = 1:
  - 8 pulses issue before the first tick, then pulses stop.
  - Each tick then decrements `pullin`, and no scheduled pulse occurs until `pullin` = 0.
